// File: rtl/tmem_pkg.sv
// Shared TMEM geometry and load-controller state encoding.
package tmem_pkg;

   localparam int TMEM_AW = 9;
   localparam int TMEM_DW = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_TURN  = 2'd2,
      ST_DONE  = 2'd3
   } tmem_state_e;

endpackage

// File: rtl/tmem_load_fifo.sv
// Small synchronous word buffer between the memory stream and the TMEM write port.
// Head word is visible combinationally so a pop can register it the same edge.
module tmem_load_fifo
   import tmem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = TMEM_DW
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == CNT_FULL);
   assign empty_o   = (count_q == {(PW + 1){1'b0}});
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign data_o    = mem_q[rd_ptr_q];

   // Storage array; contents are don't-care while empty so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointer and occupancy tracking; flush discards anything left from a prior load.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW + 1){1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW + 1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/tmem_load_ctl.sv
// TMEM load controller: buffers a word stream and writes it to consecutive TMEM
// addresses, yielding the shared bus to the texture read path whenever it claims it.
module tmem_load_ctl
   import tmem_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TMEM_AW    = tmem_pkg::TMEM_AW
) (
   input  logic               gclk,
   input  logic               reset_l,
   input  logic               load_start,
   input  logic [TMEM_AW-1:0] load_addr,
   input  logic [TMEM_AW-1:0] load_len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [TMEM_DW-1:0] in_data,
   input  logic               bus_busy,
   output logic [TMEM_DW-1:0] tmem_data_out,
   output logic               tmem_enable,
   output logic               tmem_we,
   output logic [TMEM_AW-1:0] tmem_addr,
   output logic               load_busy,
   output logic               load_done
);

   localparam logic [TMEM_AW:0]   CNT_ZERO = {(TMEM_AW + 1){1'b0}};
   localparam logic [TMEM_AW:0]   CNT_ONE  = (TMEM_AW + 1)'(1);
   localparam logic [TMEM_AW-1:0] ADDR_ONE = TMEM_AW'(1);

   tmem_state_e        state_q;
   logic [TMEM_AW-1:0] wr_addr_q;
   logic [TMEM_AW:0]   pop_left_q;
   logic [TMEM_AW:0]   acc_left_q;
   logic [TMEM_DW-1:0] data_q;
   logic [TMEM_AW-1:0] addr_q;
   logic               we_q;
   logic               busy_q;
   logic               done_q;

   logic               in_ready_s;
   logic               push_s;
   logic               pop_s;
   logic               flush_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [TMEM_DW-1:0] fifo_head_s;

   // Accept words only while a load is active, there is room, and the load still needs them.
   always_comb begin
      in_ready_s = 1'b0;
      if ((state_q == ST_WRITE || state_q == ST_TURN) && !fifo_full_s && (acc_left_q != CNT_ZERO)) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign push_s  = in_valid && in_ready_s;
   assign pop_s   = (state_q == ST_WRITE) && (pop_left_q != CNT_ZERO) && !bus_busy && !fifo_empty_s;
   assign flush_s = (state_q == ST_IDLE) && load_start;

   tmem_load_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (TMEM_DW)
   ) u_fifo (
      .clk_i   (gclk),
      .rst_n_i (reset_l),
      .flush_i (flush_s),
      .push_i  (push_s),
      .data_i  (in_data),
      .pop_i   (pop_s),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Load FSM, address/length counters and registered TMEM strobes.
   always_ff @(posedge gclk or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= ST_IDLE;
         wr_addr_q  <= {TMEM_AW{1'b0}};
         pop_left_q <= CNT_ZERO;
         acc_left_q <= CNT_ZERO;
         data_q     <= {TMEM_DW{1'b0}};
         addr_q     <= {TMEM_AW{1'b0}};
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (push_s) begin
            acc_left_q <= acc_left_q - CNT_ONE;
         end
         case (state_q)
            ST_IDLE: begin
               we_q   <= 1'b0;
               done_q <= 1'b0;
               if (load_start) begin
                  wr_addr_q  <= load_addr;
                  pop_left_q <= {1'b0, load_len} + CNT_ONE;
                  acc_left_q <= {1'b0, load_len} + CNT_ONE;
                  busy_q     <= 1'b1;
                  state_q    <= ST_WRITE;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_WRITE: begin
               // The last write is still on the bus this cycle, so DONE follows one edge later.
               if (pop_left_q == CNT_ZERO) begin
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (bus_busy) begin
                  we_q    <= 1'b0;
                  state_q <= ST_TURN;
               end else if (pop_s) begin
                  data_q     <= fifo_head_s;
                  addr_q     <= wr_addr_q;
                  we_q       <= 1'b1;
                  wr_addr_q  <= wr_addr_q + ADDR_ONE;
                  pop_left_q <= pop_left_q - CNT_ONE;
               end else begin
                  we_q <= 1'b0;
               end
            end
            ST_TURN: begin
               // The edge leaving TURN yields one idle bus cycle for turnaround.
               we_q <= 1'b0;
               if (!bus_busy) begin
                  state_q <= ST_WRITE;
               end else begin
                  state_q <= ST_TURN;
               end
            end
            ST_DONE: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_s;
   assign tmem_data_out = data_q;
   assign tmem_addr     = addr_q;
   assign tmem_enable   = we_q;
   assign tmem_we       = we_q;
   assign load_busy     = busy_q;
   assign load_done     = done_q;

endmodule

// File: tb/tb_tmem_load_ctl.sv
// Scoreboard bench for tmem_load_ctl: accepted words are queued with their target
// address and checked against each observed TMEM write.
module tb_tmem_load_ctl;

   typedef struct packed {
      logic [8:0]  addr;
      logic [63:0] data;
   } sb_t;

   logic        gclk = 1'b0;
   logic        reset_l;
   logic        load_start;
   logic [8:0]  load_addr;
   logic [8:0]  load_len;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        bus_busy;
   logic [63:0] tmem_data_out;
   logic        tmem_enable;
   logic        tmem_we;
   logic [8:0]  tmem_addr;
   logic        load_busy;
   logic        load_done;

   int   n_checks = 0;
   int   n_errors = 0;
   sb_t  sb_q[$];
   int   cyc = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   int   first_wr = -1;
   int   last_wr = 0;
   int   max_gap = 0;
   int   start_cyc = 0;
   int   acc_cnt = 0;
   int   acc_target = 0;
   bit   drv_en = 1'b0;
   bit   rnd_valid = 1'b0;
   bit   rdy_checked = 1'b0;
   logic [8:0] next_addr = 9'd0;

   tmem_load_ctl #(
      .FIFO_DEPTH (4),
      .TMEM_AW    (9)
   ) dut (
      .gclk          (gclk),
      .reset_l       (reset_l),
      .load_start    (load_start),
      .load_addr     (load_addr),
      .load_len      (load_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .bus_busy      (bus_busy),
      .tmem_data_out (tmem_data_out),
      .tmem_enable   (tmem_enable),
      .tmem_we       (tmem_we),
      .tmem_addr     (tmem_addr),
      .load_busy     (load_busy),
      .load_done     (load_done)
   );

   always #5 gclk = ~gclk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stream driver: offers words and records every handshake in the scoreboard.
   initial begin
      sb_t e;
      forever begin
         @(negedge gclk);
         if (drv_en && reset_l) begin
            if (acc_cnt == acc_target && load_busy && !rdy_checked) begin
               check_eq("ready_low_when_all_accepted", {63'd0, in_ready}, 64'd0);
               rdy_checked = 1'b1;
            end
            in_valid = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = {$urandom(), $urandom()};
            if (in_valid && in_ready) begin
               e.addr = next_addr;
               e.data = in_data;
               sb_q.push_back(e);
               next_addr = next_addr + 9'd1;
               acc_cnt++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   // Write monitor: pops the scoreboard on every TMEM write strobe.
   initial begin
      sb_t e;
      forever begin
         @(negedge gclk);
         cyc++;
         if (reset_l) begin
            if (load_done) done_cnt++;
            if (tmem_we) begin
               check_eq("wr_enable", {63'd0, tmem_enable}, 64'd1);
               check_eq("sb_nonempty", {63'd0, (sb_q.size() != 0)}, 64'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check_eq("wr_addr", {55'd0, tmem_addr}, {55'd0, e.addr});
                  check_eq("wr_data", tmem_data_out, e.data);
               end
               wr_cnt++;
               if (first_wr < 0) first_wr = cyc;
               else if (cyc - last_wr > max_gap) max_gap = cyc - last_wr;
               last_wr = cyc;
            end
         end
      end
   end

   task automatic start_load(input logic [8:0] addr, input logic [8:0] len, input bit rnd);
      @(negedge gclk);
      wr_cnt = 0; done_cnt = 0; first_wr = -1; max_gap = 0;
      acc_cnt = 0; acc_target = int'(len) + 1; rdy_checked = 1'b0;
      next_addr = addr; rnd_valid = rnd;
      load_addr = addr; load_len = len; load_start = 1'b1;
      drv_en = 1'b1;
      #1 start_cyc = cyc;
      @(negedge gclk);
      load_start = 1'b0;
   endtask

   task automatic wait_wr(input int n);
      for (int i = 0; i < 300; i++) begin
         @(negedge gclk);
         #1;
         if (wr_cnt >= n) break;
      end
      check_eq("wait_wr", wr_cnt, n);
   endtask

   task automatic finish_load(input int len, input int lat, input int gap);
      for (int i = 0; i < 400; i++) begin
         @(negedge gclk);
         #1;
         if (done_cnt > 0 && !load_busy) break;
      end
      drv_en = 1'b0;
      check_eq("done_pulses", done_cnt, 1);
      check_eq("busy_dropped", {63'd0, load_busy}, 64'd0);
      check_eq("wr_count", wr_cnt, len + 1);
      check_eq("acc_count", acc_cnt, len + 1);
      check_eq("sb_drained", sb_q.size(), 0);
      if (lat >= 0) check_eq("first_wr_latency", first_wr - start_cyc, lat);
      if (gap >= 0) check_eq("max_wr_gap", max_gap, gap);
   endtask

   initial begin
      int snap;
      reset_l = 1'b0; load_start = 1'b0; load_addr = 9'd0; load_len = 9'd0;
      in_valid = 1'b0; in_data = 64'd0; bus_busy = 1'b0;
      repeat (3) @(negedge gclk);
      check_eq("rst_enable", {63'd0, tmem_enable}, 64'd0);
      check_eq("rst_we", {63'd0, tmem_we}, 64'd0);
      check_eq("rst_ready", {63'd0, in_ready}, 64'd0);
      check_eq("rst_busy", {63'd0, load_busy}, 64'd0);
      check_eq("rst_addr", {55'd0, tmem_addr}, 64'd0);
      reset_l = 1'b1;
      repeat (2) @(negedge gclk);

      start_load(9'h010, 9'd3, 1'b0);
      finish_load(3, 3, 1);

      start_load(9'h1FE, 9'd3, 1'b0);
      finish_load(3, 3, 1);

      start_load(9'h0A0, 9'd0, 1'b0);
      finish_load(0, 3, -1);

      // Bus claimed for three edges after the second write.
      start_load(9'h080, 9'd7, 1'b0);
      wait_wr(2);
      bus_busy = 1'b1;
      repeat (3) @(negedge gclk);
      bus_busy = 1'b0;
      finish_load(7, 3, 5);

      start_load(9'h150, 9'd15, 1'b1);
      finish_load(15, -1, -1);

      // A second start mid-load must not disturb the running load.
      start_load(9'h020, 9'd5, 1'b0);
      wait_wr(1);
      load_addr = 9'h1A0; load_len = 9'd1; load_start = 1'b1;
      @(negedge gclk);
      load_start = 1'b0;
      finish_load(5, 3, 1);

      // Reset in the middle of an 8-word load.
      start_load(9'h100, 9'd7, 1'b0);
      wait_wr(2);
      reset_l = 1'b0;
      drv_en = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      #1;
      check_eq("mid_rst_enable", {63'd0, tmem_enable}, 64'd0);
      check_eq("mid_rst_we", {63'd0, tmem_we}, 64'd0);
      check_eq("mid_rst_data", tmem_data_out, 64'd0);
      check_eq("mid_rst_addr", {55'd0, tmem_addr}, 64'd0);
      check_eq("mid_rst_ready", {63'd0, in_ready}, 64'd0);
      check_eq("mid_rst_busy", {63'd0, load_busy}, 64'd0);
      check_eq("mid_rst_done", {63'd0, load_done}, 64'd0);
      snap = wr_cnt;
      repeat (3) @(negedge gclk);
      reset_l = 1'b1;
      repeat (6) @(negedge gclk);
      #1;
      check_eq("no_wr_after_rst", wr_cnt, snap);
      start_load(9'h040, 9'd3, 1'b0);
      finish_load(3, 3, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tmem_load_ctl.md
TMEM_LOAD_CTL -- requirements
Module: tmem_load_ctl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the input word buffer depth (power of two, at least 2).
REQ-002 SHALL have parameter TMEM_AW, default 9, meaning the TMEM word address width (512 x 64-bit words).
REQ-003 SHALL have port gclk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_l, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_start, input, 1, a one-cycle pulse that starts a load.
REQ-006 SHALL have port load_addr, input, TMEM_AW, the first TMEM word address, sampled on load_start.
REQ-007 SHALL have port load_len, input, TMEM_AW, the word count minus 1, sampled on load_start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 64), a valid/ready word stream from the memory interface.
REQ-009 SHALL have port bus_busy, input, 1, the texture read path's claim on the TMEM bus for the next cycle.
REQ-010 SHALL have ports tmem_data_out (output, 64), tmem_enable (output, 1), tmem_we (output, 1) and tmem_addr (output, TMEM_AW), which feed the TMEM tristate driver and write strobe.
REQ-011 SHALL have ports load_busy (output, 1), high from load_start until done, and load_done (output, 1), a one-cycle pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, TURN and DONE.
REQ-013 IDLE->WRITE on load_start; sample load_addr into wr_addr and load_len into the remaining and accept counters; flush the FIFO.
REQ-014 load_start outside IDLE SHALL be ignored, with no effect on counters or FIFO.
REQ-015 in_ready = (state != IDLE and state != DONE) and FIFO not full and accepted count < load_len+1; a push occurs when in_valid & in_ready.
REQ-016 in WRITE, if FIFO non-empty and bus_busy low at the edge: pop head; next cycle tmem_data_out = head, tmem_enable = 1, tmem_we = 1, tmem_addr = wr_addr; wr_addr increments.
REQ-017 Otherwise in WRITE, tmem_enable = 0 and tmem_we = 0 in the next cycle; tmem_data_out holds its last value.
REQ-018 bus_busy high in WRITE SHALL force WRITE->TURN; tmem_enable is low in the cycle after bus_busy is sampled high.
REQ-019 TURN SHALL stay while bus_busy is high, then hold one further cycle with tmem_enable low (bus turnaround) before returning to WRITE.
REQ-020 Minimum latency: a word accepted at edge k SHALL appear with tmem_we high in the cycle after edge k+1.
REQ-021 wr_addr SHALL wrap modulo 2^TMEM_AW (511 -> 0) with no error.
REQ-022 push and pop in the same cycle SHALL be allowed when the FIFO is non-empty, leaving occupancy unchanged; a push when full cannot occur per REQ-015.
REQ-023 After the pop of word load_len+1, the FSM SHALL go WRITE->DONE; DONE asserts load_done for one cycle, then goes to IDLE; load_busy drops with it.
REQ-024 load_len = 0 SHALL load exactly one word.
REQ-025 tmem_enable and tmem_we SHALL never be high in IDLE, TURN or DONE.

Reset
REQ-026 reset_l low SHALL immediately force IDLE, empty the FIFO, and zero tmem_enable, tmem_we, tmem_data_out, tmem_addr, in_ready, load_busy and load_done, including mid-load.
REQ-027 After deassertion, no TMEM write SHALL occur before a new load_start.

Structure
REQ-028 Package tmem_pkg SHALL hold TMEM_AW, TMEM_DW = 64, and the FSM state typedef.
REQ-029 A single sub-module tmem_load_fifo (synchronous FIFO, flush input, full/empty flags) SHALL hold the word buffer; FSM and counters stay in tmem_load_ctl.

Verification
REQ-030 load_addr=0x010, load_len=3, in_valid held high, bus_busy=0 -> writes to 0x010..0x013 on 4 consecutive cycles, then a single load_done pulse.
REQ-031 load_addr=0x1FE, load_len=3 -> tmem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
REQ-032 bus_busy high for 3 cycles mid-load -> tmem_enable low from the next cycle through the 3 busy cycles plus 1 turnaround cycle; no word lost or duplicated.
REQ-033 in_valid toggled randomly, load_len=15 -> exactly 16 writes in order; in_ready low once 16 words are accepted.
REQ-034 reset_l pulsed low after the 2nd write of an 8-word load -> all outputs 0 immediately; a new load_start to 0x040 writes from 0x040 with no stale data.
REQ-035 load_start while load_busy -> ignored, and the original load completes unchanged.
